// File: rtl/sd_sector_loader_if.sv
// sd_sector_loader_if
//   Bundles the request, SD-controller and RAM-write signals of the sector loader.
//   The loader itself uses the slave modport. The requesting logic and the SD
//   controller/RAM side use the master modport.
//
//   Handshakes:
//     start/busy : start is a 1-cycle request. It is accepted only while busy=0.
//                  busy stays high until the cycle in which done pulses.
//     sd_rd/sd_ready : sd_rd (request) is raised only while sd_ready=1. The
//                  controller takes the request by dropping sd_ready. sd_rd
//                  falls no later than the cycle in which sd_ready is seen low.
//     sd_byte_available : a 1-cycle strobe qualifying sd_dout. It has no backpressure.
//     mem_we     : a 1-cycle write strobe qualifying mem_addr/mem_wdata. It has no backpressure.
//   dbg_state exposes the loader FSM encoding for observation.
interface sd_sector_loader_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [31:0]       start_sector;
  logic [15:0]       sector_count;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              error;
  logic              sd_rd;
  logic [31:0]       sd_address;
  logic              sd_ready;
  logic              sd_byte_available;
  logic [7:0]        sd_dout;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [2:0]        dbg_state;

  modport slave (
    input  start, start_sector, sector_count, base_addr,
    input  sd_ready, sd_byte_available, sd_dout,
    output busy, done, error, sd_rd, sd_address,
    output mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport master (
    output start, start_sector, sector_count, base_addr,
    output sd_ready, sd_byte_available, sd_dout,
    input  busy, done, error, sd_rd, sd_address,
    input  mem_we, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/sd_sector_loader.sv
// sd_sector_loader
//   Multi-sector read sequencer that sits behind an SPI-mode SD card controller.
//   It issues one 512-byte block read per sector. Each received byte is written
//   sequentially into a byte-wide RAM. The loader then reports done, with error
//   set if the operation timed out.
// Ports
//   clk   : system clock. This is the same clock that the SD controller uses.
//   reset : asynchronous, active-high reset.
//   bus   : sd_sector_loader_if.slave. It carries the following groups:
//             request        : start, start_sector, sector_count, base_addr
//             status         : busy, done, error
//             SD controller  : sd_rd, sd_address, sd_ready, sd_byte_available, sd_dout
//             RAM write      : mem_we, mem_addr, mem_wdata
//             debug          : dbg_state
module sd_sector_loader #(
  parameter int ADDR_W         = 16,
  parameter int ADDR_SHIFT     = 9,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input logic                clk,
  input logic                reset,
  sd_sector_loader_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAITR = 3'd1,
    S_ISSUE = 3'd2,
    S_RECV  = 3'd3,
    S_NEXT  = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_sector;
  logic [15:0]       r_remaining;
  logic [ADDR_W-1:0] r_waddr;
  logic [9:0]        r_byte_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_sd_rd;
  logic [31:0]       r_sd_address;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_done;
  logic              r_error;
  logic              w_timeout;
  logic              w_tmo_run;

  assign w_timeout = (r_tmo == TMO_W'(TIMEOUT_CYCLES));
  assign w_tmo_run = (r_state == S_WAITR) || (r_state == S_ISSUE) ||
                     (r_state == S_RECV)  || (r_state == S_DRAIN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic. Timeout has priority over normal progress in every waiting state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = (bus.sector_count == 16'd0) ? S_FIN : S_WAITR;
      S_WAITR: if (w_timeout) w_state_next = S_FIN;
               else if (bus.sd_ready) w_state_next = S_ISSUE;
      S_ISSUE: if (w_timeout) w_state_next = S_FIN;
               else if (!bus.sd_ready) w_state_next = S_RECV;
      S_RECV:  if (w_timeout) w_state_next = S_FIN;
               else if (bus.sd_byte_available && (r_byte_cnt == 10'd511)) w_state_next = S_NEXT;
      S_NEXT:  w_state_next = (r_remaining == 16'd1) ? S_DRAIN : S_WAITR;
      S_DRAIN: if (w_timeout || bus.sd_ready) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sector     <= '0;
      r_remaining  <= '0;
      r_waddr      <= '0;
      r_byte_cnt   <= '0;
      r_tmo        <= '0;
      r_sd_rd      <= 1'b0;
      r_sd_address <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;

      // The progress watchdog restarts on any state change or any byte strobe.
      if (!w_tmo_run || (w_state_next != r_state) || bus.sd_byte_available)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TMO_W'(1);

      case (r_state)
        S_IDLE: if (bus.start) begin
          r_sector    <= bus.start_sector;
          r_remaining <= bus.sector_count;
          r_waddr     <= bus.base_addr;
          r_error     <= 1'b0;
        end
        S_WAITR: if (w_timeout) begin
          r_error <= 1'b1;
        end else if (bus.sd_ready) begin
          r_sd_rd      <= 1'b1;
          r_sd_address <= r_sector << ADDR_SHIFT;
        end
        S_ISSUE: if (w_timeout) begin
          r_error <= 1'b1;
          r_sd_rd <= 1'b0;
        end else if (!bus.sd_ready) begin
          r_sd_rd    <= 1'b0;
          r_byte_cnt <= '0;
        end
        S_RECV: if (w_timeout) begin
          r_error <= 1'b1;
        end else if (bus.sd_byte_available) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_waddr;
          r_mem_wdata <= bus.sd_dout;
          r_waddr     <= r_waddr + ADDR_W'(1);
          r_byte_cnt  <= r_byte_cnt + 10'd1;
        end
        S_NEXT: begin
          r_sector    <= r_sector + 32'd1;
          r_remaining <= r_remaining - 16'd1;
        end
        S_DRAIN: if (w_timeout) r_error <= 1'b1;
        S_FIN:   r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  // The request is gated with sd_ready. This drops sd_rd in the same cycle
  // that the controller takes the request, and it also drops sd_rd on reset.
  assign bus.sd_rd      = r_sd_rd & bus.sd_ready;
  assign bus.sd_address = r_sd_address;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_sd_sector_loader.sv
// tb_sd_sector_loader
//   Directed bench for sd_sector_loader. A behavioural SD controller streams
//   512 bytes per accepted read. A scoreboard compares the RAM writes against an
//   expected queue that is derived from the requested sectors and base address.
module tb_sd_sector_loader;
  localparam int ADDR_W = 16;
  localparam int W      = ADDR_W + 8;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_sector_loader_if #(.ADDR_W(ADDR_W)) bus();

  sd_sector_loader #(
    .ADDR_W(ADDR_W), .ADDR_SHIFT(9), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0]  exp_q[$];     // expected {addr, data} per write (main-owned)
  logic [W-1:0]  obs_q[$];     // observed writes (monitor-owned)
  logic [31:0]   exp_rd_q[$];  // expected read addresses (main-owned)
  logic [31:0]   got_rd_q[$];  // accepted read addresses (model-owned)
  int            rd_viol = 0;  // sd_rd high while sd_ready low (monitor-owned)
  int            stall_after = -1;
  bit            model_abort = 1'b0;
  bit            model_idle;

  typedef struct {
    logic [31:0] sector;
    logic [15:0] count;
    logic [15:0] base;
    int          exp_writes;
    int          exp_rd;
    logic [31:0] exp_first_rd;
    logic [15:0] exp_first_wa;
    logic [15:0] exp_last_wa;
  } vec_t;

  function automatic logic [7:0] model_byte(input logic [7:0] sec, input int idx);
    return 8'(int'(sec) * 13 + idx * 7 + (idx >> 8));
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // SD controller model. It takes a request seen on sd_rd, drops sd_ready,
  // streams 512 bytes one every 2 cycles, waits for the CRC, then raises sd_ready again.
  initial begin
    logic [31:0] addr;
    bit stalled;
    bus.sd_ready = 1'b1;
    bus.sd_byte_available = 1'b0;
    bus.sd_dout = 8'h00;
    model_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.sd_rd) begin
        addr = bus.sd_address;
        got_rd_q.push_back(addr);
        model_idle = 1'b0;
        bus.sd_ready = 1'b0;
        repeat (3) @(negedge clk);
        stalled = 1'b0;
        for (int i = 0; i < 512; i++) begin
          if (stall_after >= 0 && i == stall_after) begin
            stalled = 1'b1;
            break;
          end
          bus.sd_dout = model_byte(addr[16:9], i);
          bus.sd_byte_available = 1'b1;
          @(negedge clk);
          bus.sd_byte_available = 1'b0;
          @(negedge clk);
        end
        if (stalled) while (!model_abort) @(negedge clk);
        else repeat (4) @(negedge clk);
        bus.sd_ready = 1'b1;
        model_idle = 1'b1;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (bus.mem_we) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.sd_rd && !bus.sd_ready) rd_viol++;
  end

  // Driver tasks
  task automatic start_op(input logic [31:0] sec, input logic [15:0] cnt, input logic [15:0] base);
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_sector = sec;
    bus.sector_count = cnt;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic build_expect(input logic [31:0] sec, input logic [15:0] cnt, input logic [15:0] base);
    logic [31:0] s;
    logic [15:0] wa;
    exp_q.delete();
    exp_rd_q.delete();
    wa = base;
    for (int k = 0; k < int'(cnt); k++) begin
      s = sec + 32'(k);
      exp_rd_q.push_back(s << 9);
      for (int b = 0; b < 512; b++) begin
        exp_q.push_back({wa, model_byte(s[7:0], b)});
        wa = wa + 16'd1;
      end
    end
  endtask

  // Scoreboard: compares the writes observed since obs_base against exp_q.
  task automatic score_writes(input string tag, input int obs_base);
    int n, bad;
    n = obs_q.size() - obs_base;
    bad = 0;
    for (int k = 0; k < n && k < exp_q.size(); k++)
      if (obs_q[obs_base + k] !== exp_q[k]) bad++;
    check({tag, "_write_count"}, 64'(n), 64'(exp_q.size()));
    check({tag, "_write_data"}, 64'(bad), 64'd0);
  endtask

  task automatic score_reads(input string tag, input int rd_base);
    int n;
    n = got_rd_q.size() - rd_base;
    check({tag, "_rd_count"}, 64'(n), 64'(exp_rd_q.size()));
    for (int k = 0; k < n && k < exp_rd_q.size(); k++)
      check($sformatf("%s_rd_addr%0d", tag, k), 64'(got_rd_q[rd_base + k]), 64'(exp_rd_q[k]));
  endtask

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    bit   seen;
    int   ob, rb, vb, n;

    vecs[0] = '{32'd5,          16'd1, 16'h0100, 512,  1, 32'h0000_0A00, 16'h0100, 16'h02FF};
    vecs[1] = '{32'd5,          16'd3, 16'h1000, 1536, 3, 32'h0000_0A00, 16'h1000, 16'h15FF};
    vecs[2] = '{32'd9,          16'd0, 16'h0000, 0,    0, 32'h0000_0000, 16'h0000, 16'h0000};
    vecs[3] = '{32'hFFFF_FFFF,  16'd2, 16'hFFFC, 1024, 2, 32'hFFFF_FE00, 16'hFFFC, 16'h03FB};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.start_sector = '0;
    bus.sector_count = '0;
    bus.base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_sd_rd", 64'(bus.sd_rd), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    reset = 1'b0;

    // Table-driven loads
    for (int i = 0; i < 4; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      build_expect(vecs[i].sector, vecs[i].count, vecs[i].base);
      ob = obs_q.size(); rb = got_rd_q.size(); vb = rd_viol;
      start_op(vecs[i].sector, vecs[i].count, vecs[i].base);
      wait_done(8000, seen);
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_error"}, 64'(bus.error), 64'd0);
      check({tag, "_ready_at_done"}, 64'(bus.sd_ready), 64'd1);
      @(negedge clk);
      check({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
      check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
      score_writes(tag, ob);
      check({tag, "_exp_len"}, 64'(exp_q.size()), 64'(vecs[i].exp_writes));
      score_reads(tag, rb);
      if (vecs[i].exp_rd > 0 && got_rd_q.size() > rb)
        check({tag, "_first_rd"}, 64'(got_rd_q[rb]), 64'(vecs[i].exp_first_rd));
      if (vecs[i].exp_writes > 0 && obs_q.size() > ob) begin
        check({tag, "_first_wa"}, 64'(obs_q[ob][W-1:8]), 64'(vecs[i].exp_first_wa));
        check({tag, "_last_wa"}, 64'(obs_q[obs_q.size()-1][W-1:8]), 64'(vecs[i].exp_last_wa));
      end
      check({tag, "_rd_while_not_ready"}, 64'(rd_viol - vb), 64'd0);
    end

    // Zero-count cycle timing: busy for exactly one cycle, done two cycles after start
    rb = got_rd_q.size();
    @(negedge clk);
    bus.start = 1'b1; bus.sector_count = 16'd0; bus.start_sector = 32'd42;
    @(negedge clk);
    bus.start = 1'b0;
    check("zc_busy_c1", 64'(bus.busy), 64'd1);
    check("zc_done_c1", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("zc_busy_c2", 64'(bus.busy), 64'd0);
    check("zc_done_c2", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("zc_done_c3", 64'(bus.done), 64'd0);
    check("zc_no_rd", 64'(got_rd_q.size() - rb), 64'd0);

    // Timeout: the controller stalls forever after 100 bytes
    stall_after = 100;
    build_expect(32'd20, 16'd2, 16'h4000);
    while (exp_q.size() > 100) void'(exp_q.pop_back());
    while (exp_rd_q.size() > 1) void'(exp_rd_q.pop_back());
    ob = obs_q.size(); rb = got_rd_q.size();
    start_op(32'd20, 16'd2, 16'h4000);
    wait_done(4000, seen);
    check("tmo_done_seen", 64'(seen), 64'd1);
    check("tmo_error", 64'(bus.error), 64'd1);
    check("tmo_sd_rd", 64'(bus.sd_rd), 64'd0);
    score_writes("tmo", ob);
    score_reads("tmo", rb);
    model_abort = 1'b1;
    n = 0;
    while (!model_idle && n < 100) begin @(negedge clk); n++; end
    check("tmo_model_recovered", 64'(model_idle), 64'd1);
    model_abort = 1'b0;
    stall_after = -1;
    repeat (2) @(negedge clk);
    check("tmo_error_held", 64'(bus.error), 64'd1);
    start_op(32'd0, 16'd0, 16'h0000);
    check("tmo_error_cleared", 64'(bus.error), 64'd0);
    wait_done(10, seen);
    check("tmo_clear_done", 64'(seen), 64'd1);

    // A start pulsed mid-load is ignored
    build_expect(32'd5, 16'd1, 16'h0200);
    ob = obs_q.size(); rb = got_rd_q.size();
    start_op(32'd5, 16'd1, 16'h0200);
    repeat (100) @(negedge clk);
    check("ign_busy_mid", 64'(bus.busy), 64'd1);
    bus.start = 1'b1; bus.start_sector = 32'd99; bus.sector_count = 16'd5; bus.base_addr = 16'h7000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(4000, seen);
    check("ign_done_seen", 64'(seen), 64'd1);
    check("ign_error", 64'(bus.error), 64'd0);
    score_writes("ign", ob);
    score_reads("ign", rb);

    // Async reset in the middle of RECV
    build_expect(32'd3, 16'd2, 16'h0000);
    ob = obs_q.size(); rb = got_rd_q.size();
    start_op(32'd3, 16'd2, 16'h0000);
    n = 0;
    while ((obs_q.size() - ob) < 50 && n < 1000) begin @(negedge clk); n++; end
    check("rr_reached_50", 64'((obs_q.size() - ob) >= 50), 64'd1);
    check("rr_state_recv", 64'(bus.dbg_state), 64'd3);
    reset = 1'b1;
    #1;
    check("rr_busy", 64'(bus.busy), 64'd0);
    check("rr_done", 64'(bus.done), 64'd0);
    check("rr_error", 64'(bus.error), 64'd0);
    check("rr_sd_rd", 64'(bus.sd_rd), 64'd0);
    check("rr_sd_address", 64'(bus.sd_address), 64'd0);
    check("rr_mem_we", 64'(bus.mem_we), 64'd0);
    check("rr_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rr_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    while (exp_q.size() > (obs_q.size() - ob)) void'(exp_q.pop_back());
    score_writes("rr_prefix", ob);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = obs_q.size();
    vb = 0;
    while (!model_idle && vb < 2000) begin @(negedge clk); vb++; end
    check("rr_model_finished", 64'(model_idle), 64'd1);
    repeat (5) @(negedge clk);
    check("rr_no_trailing_we", 64'(obs_q.size() - n), 64'd0);
    check("rr_rd_count", 64'(got_rd_q.size() - rb), 64'd1);
    check("rr_idle_busy", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
